// File: rtl/rot_seq_ctrl.sv
// Serialised multi-step rotate controller: one single-bit rotate per clock, one operation in flight.
// Optional left rotation is compiled in when ROT_SEQ_LEFT_EN is defined.
module rot_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [AMT_W-1:0] CntOne = AMT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q;
  logic [WIDTH-1:0] rot_r;

  assign rot_r = {data_q[0], data_q[WIDTH-1:1]};

`ifdef ROT_SEQ_LEFT_EN
  logic             dir_d;
  logic [WIDTH-1:0] rot_l;

  assign rot_l = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`else
  // Direction input has no function in the right-only build.
  logic unused_in_dir;

  assign dir_q         = 1'b0;
  assign unused_in_dir = in_dir;
`endif

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef ROT_SEQ_LEFT_EN
    dir_d   = dir_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_amt;
`ifdef ROT_SEQ_LEFT_EN
          dir_d   = in_dir;
`endif
          state_d = (in_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
`ifdef ROT_SEQ_LEFT_EN
        data_d = dir_q ? rot_l : rot_r;
`else
        data_d = rot_r;
`endif
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef ROT_SEQ_LEFT_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef ROT_SEQ_LEFT_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Ready is masked by reset directly so a request is never taken in the reset cycle.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

endmodule
